// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StDispense,
    StChange
  } state_e;

  localparam logic [1:0] CoinInvalid = 2'b00;
  localparam logic [1:0] CoinOne     = 2'b01;
  localparam logic [1:0] CoinTwo     = 2'b10;
  localparam logic [1:0] CoinFour    = 2'b11;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    logic [2:0] units;
    case (code)
      CoinOne:  units = 3'd1;
      CoinTwo:  units = 3'd2;
      CoinFour: units = 3'd4;
      default:  units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Front-end, dispenser and change-mechanism signals of the vending controller.
interface vend_ctrl_if #(
  parameter int unsigned CREDIT_W = 6,
  parameter int unsigned N_PROD   = 4
);
  localparam int unsigned ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  logic                coin_valid;
  logic [1:0]          coin_code;
  logic                sel_valid;
  logic [ID_W-1:0]     sel_id;
  logic                cancel;
  logic                cfg_we;
  logic [ID_W-1:0]     cfg_addr;
  logic [CREDIT_W-1:0] cfg_price;
  logic                disp_req;
  logic [ID_W-1:0]     disp_id;
  logic                disp_ack;
  logic                chg_req;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                no_funds;
  logic                busy;

  // Environment side: coin acceptor, keypad, config host and mechanisms.
  modport master (
    output coin_valid, coin_code, sel_valid, sel_id, cancel,
    output cfg_we, cfg_addr, cfg_price, disp_ack, chg_ack,
    input  disp_req, disp_id, chg_req, credit, coin_reject, no_funds, busy
  );

  // Controller side.
  modport slave (
    input  coin_valid, coin_code, sel_valid, sel_id, cancel,
    input  cfg_we, cfg_addr, cfg_price, disp_ack, chg_ack,
    output disp_req, disp_id, chg_req, credit, coin_reject, no_funds, busy
  );

endinterface

// File: rtl/vend_price_table.sv
// Per-product price registers: one write port, one combinational read port.
module vend_price_table #(
  parameter int unsigned CREDIT_W      = 6,
  parameter int unsigned N_PROD        = 4,
  parameter int unsigned DEFAULT_PRICE = 3,
  localparam int unsigned ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ID_W-1:0]     waddr,
  input  logic [CREDIT_W-1:0] wdata,
  input  logic [ID_W-1:0]     raddr,
  output logic [CREDIT_W-1:0] rdata
);

  logic [CREDIT_W-1:0] price_q [N_PROD];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_PROD; i++) begin
        price_q[i] <= CREDIT_W'(DEFAULT_PRICE);
      end
    end else if (we) begin
      price_q[waddr] <= wdata;
    end
  end

  assign rdata = price_q[raddr];

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: credit accumulation, selection, dispense and change return.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W      = 6,
  parameter int unsigned N_PROD        = 4,
  parameter int unsigned DEFAULT_PRICE = 3,
  parameter int unsigned TIMEOUT       = 1000
) (
  input logic         clk,
  input logic         rst,
  vend_ctrl_if.slave  bus
);

  localparam int unsigned ID_W    = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CREDIT_W:0] CreditMax = {1'b0, {CREDIT_W{1'b1}}};

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [ID_W-1:0]     disp_id_q, disp_id_d;
  logic                coin_reject_q, coin_reject_d;
  logic                no_funds_q, no_funds_d;

  logic [CREDIT_W-1:0] price;
  logic [2:0]          coin_units;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                timeout;

  vend_price_table #(
    .CREDIT_W      (CREDIT_W),
    .N_PROD        (N_PROD),
    .DEFAULT_PRICE (DEFAULT_PRICE)
  ) u_price_table (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.cfg_we && (state_q == StIdle)),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_price),
    .raddr (bus.sel_id),
    .rdata (price)
  );

  assign coin_units = coin_value(bus.coin_code);
  // One extra bit so an overflowing coin is detected instead of wrapping.
  assign coin_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_units);
  assign coin_ok    = bus.coin_valid && (coin_units != 3'd0) && (coin_sum <= CreditMax);
  assign timeout    = (timer_q == TIMER_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    timer_d       = timer_q;
    disp_id_d     = disp_id_q;
    coin_reject_d = 1'b0;
    no_funds_d    = 1'b0;
    case (state_q)
      StIdle: begin
        no_funds_d = bus.sel_valid;
        if (bus.coin_valid) begin
          if (coin_units == 3'd0) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = CREDIT_W'(coin_units);
            timer_d  = '0;
            state_d  = StCredit;
          end
        end
      end
      StCredit: begin
        if (bus.cancel) begin
          coin_reject_d = bus.coin_valid;
          state_d       = StChange;
        end else if (bus.sel_valid) begin
          coin_reject_d = bus.coin_valid;
          if (credit_q >= price) begin
            credit_d  = credit_q - price;
            disp_id_d = bus.sel_id;
            state_d   = StDispense;
          end else begin
            no_funds_d = 1'b1;
            timer_d    = '0;
          end
        end else if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          timer_d  = '0;
        end else begin
          coin_reject_d = bus.coin_valid;
          if (timeout) begin
            state_d = StChange;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      StDispense: begin
        coin_reject_d = bus.coin_valid;
        if (bus.disp_ack) begin
          state_d = (credit_q != '0) ? StChange : StIdle;
        end
      end
      StChange: begin
        coin_reject_d = bus.coin_valid;
        if (credit_q == '0) begin
          state_d = StIdle;
        end else if (bus.chg_ack) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      timer_q       <= '0;
      disp_id_q     <= '0;
      coin_reject_q <= 1'b0;
      no_funds_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      disp_id_q     <= disp_id_d;
      coin_reject_q <= coin_reject_d;
      no_funds_q    <= no_funds_d;
    end
  end

  // Handshake outputs are decoded from registered state only.
  assign bus.disp_req    = (state_q == StDispense);
  assign bus.disp_id     = disp_id_q;
  assign bus.chg_req     = (state_q == StChange) && (credit_q != '0);
  assign bus.credit      = credit_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.no_funds    = no_funds_q;
  assign bus.busy        = (state_q == StDispense) || (state_q == StChange);

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed vector table, corner sequences, random vs model.
module tb_vend_ctrl;

  localparam int CW   = 3;
  localparam int NP   = 4;
  localparam int DP   = 3;
  localparam int TO   = 50;
  localparam int CMAX = (1 << CW) - 1;

  localparam int MIdle   = 0;
  localparam int MCredit = 1;
  localparam int MDisp   = 2;
  localparam int MChange = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vend_ctrl_if #(.CREDIT_W(CW), .N_PROD(NP)) vif ();

  vend_ctrl #(
    .CREDIT_W      (CW),
    .N_PROD        (NP),
    .DEFAULT_PRICE (DP),
    .TIMEOUT       (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: transaction mode, credit in units, idle counter, price list.
  int m_mode    = MIdle;
  int m_credit  = 0;
  int m_timer   = 0;
  int m_disp_id = 0;
  int m_rej     = 0;
  int m_nf      = 0;
  int m_price [NP];

  typedef struct {
    int cv, cc, sv, sid, can, dack, cack;
    int credit, busy, dreq, creq, rej, nf, did;
  } vec_t;

  vec_t vecs [$];

  function automatic int units(input logic [1:0] code);
    case (code)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int v;
    m_rej = 0;
    m_nf  = 0;
    if (rst) begin
      m_mode = MIdle; m_credit = 0; m_timer = 0; m_disp_id = 0;
      foreach (m_price[i]) m_price[i] = DP;
      return;
    end
    v = vif.coin_valid ? units(vif.coin_code) : 0;
    case (m_mode)
      MIdle: begin
        if (vif.cfg_we) m_price[vif.cfg_addr] = int'(vif.cfg_price);
        if (vif.sel_valid) m_nf = 1;
        if (vif.coin_valid) begin
          if (v == 0) m_rej = 1;
          else begin m_credit = v; m_timer = 0; m_mode = MCredit; end
        end
      end
      MCredit: begin
        if (vif.cancel || vif.sel_valid) begin
          if (vif.coin_valid) m_rej = 1;
          if (vif.cancel) m_mode = MChange;
          else if (m_credit >= m_price[vif.sel_id]) begin
            m_credit  = m_credit - m_price[vif.sel_id];
            m_disp_id = int'(vif.sel_id);
            m_mode    = MDisp;
          end else begin
            m_nf = 1; m_timer = 0;
          end
        end else if (vif.coin_valid && v > 0 && m_credit + v <= CMAX) begin
          m_credit = m_credit + v; m_timer = 0;
        end else begin
          if (vif.coin_valid) m_rej = 1;
          if (m_timer == TO - 1) m_mode = MChange;
          else m_timer++;
        end
      end
      MDisp: begin
        if (vif.coin_valid) m_rej = 1;
        if (vif.disp_ack) m_mode = (m_credit > 0) ? MChange : MIdle;
      end
      default: begin
        if (vif.coin_valid) m_rej = 1;
        if (vif.chg_ack && m_credit > 0) m_credit--;
        if (m_credit == 0) m_mode = MIdle;
      end
    endcase
  endtask

  task automatic clr();
    rst            = 1'b0;
    vif.coin_valid = 1'b0; vif.coin_code = 2'b00;
    vif.sel_valid  = 1'b0; vif.sel_id    = '0;
    vif.cancel     = 1'b0;
    vif.cfg_we     = 1'b0; vif.cfg_addr  = '0; vif.cfg_price = '0;
    vif.disp_ack   = 1'b0; vif.chg_ack   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    clr();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic coin(input logic [1:0] code);
    vif.coin_valid = 1'b1; vif.coin_code = code;
  endtask

  task automatic sel(input int id);
    vif.sel_valid = 1'b1; vif.sel_id = 2'(id);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_credit"}, int'(vif.credit), m_credit);
    chk({tag, "_busy"}, int'(vif.busy), (m_mode == MDisp || m_mode == MChange) ? 1 : 0);
    chk({tag, "_disp_req"}, int'(vif.disp_req), (m_mode == MDisp) ? 1 : 0);
    chk({tag, "_chg_req"}, int'(vif.chg_req), (m_mode == MChange && m_credit > 0) ? 1 : 0);
    chk({tag, "_coin_reject"}, int'(vif.coin_reject), m_rej);
    chk({tag, "_no_funds"}, int'(vif.no_funds), m_nf);
    if (m_mode == MDisp) chk({tag, "_disp_id"}, int'(vif.disp_id), m_disp_id);
  endtask

  initial begin
    vec_t v;
    foreach (m_price[i]) m_price[i] = DP;
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_credit", int'(vif.credit), 0);
    chk("rst_busy", int'(vif.busy), 0);
    chk("rst_disp_req", int'(vif.disp_req), 0);
    chk("rst_chg_req", int'(vif.chg_req), 0);
    chk("rst_flags", int'({vif.coin_reject, vif.no_funds}), 0);

    //             cv cc sv sid can da ca  cr bz dr cq rj nf did
    vecs.push_back('{1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 2, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 2, 0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 0, 0, 0,  3, 1, 1, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,  3, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 2, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 2, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 0, 0,  2, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 0,  2, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      v = vecs[i];
      vif.coin_valid = 1'(v.cv);   vif.coin_code = 2'(v.cc);
      vif.sel_valid  = 1'(v.sv);   vif.sel_id    = 2'(v.sid);
      vif.cancel     = 1'(v.can);
      vif.disp_ack   = 1'(v.dack); vif.chg_ack   = 1'(v.cack);
      tick();
      chk($sformatf("vec%0d_credit", i), int'(vif.credit), v.credit);
      chk($sformatf("vec%0d_busy", i), int'(vif.busy), v.busy);
      chk($sformatf("vec%0d_disp_req", i), int'(vif.disp_req), v.dreq);
      chk($sformatf("vec%0d_chg_req", i), int'(vif.chg_req), v.creq);
      chk($sformatf("vec%0d_coin_reject", i), int'(vif.coin_reject), v.rej);
      chk($sformatf("vec%0d_no_funds", i), int'(vif.no_funds), v.nf);
      if (v.dreq != 0) chk($sformatf("vec%0d_disp_id", i), int'(vif.disp_id), v.did);
    end

    // Overflow reject, then coin coincident with cancel and a 6-unit refund.
    coin(2'b11); tick();
    coin(2'b10); tick();
    chk("ovf_pre_credit", int'(vif.credit), 6);
    coin(2'b10); tick();
    chk("ovf_credit", int'(vif.credit), 6);
    chk("ovf_reject", int'(vif.coin_reject), 1);
    coin(2'b10); vif.cancel = 1'b1; tick();
    chk("cancel_coin_reject", int'(vif.coin_reject), 1);
    chk("cancel_chg_req", int'(vif.chg_req), 1);
    chk("cancel_credit", int'(vif.credit), 6);
    for (int k = 1; k <= 6; k++) begin
      vif.chg_ack = 1'b1; tick();
      chk($sformatf("refund%0d_credit", k), int'(vif.credit), 6 - k);
    end
    chk("refund_done_busy", int'(vif.busy), 0);
    chk("refund_done_chg_req", int'(vif.chg_req), 0);

    // Inactivity timeout: CHANGE after exactly TO idle cycles in CREDIT.
    coin(2'b10); tick();
    for (int k = 1; k < TO; k++) tick();
    chk("to_early_busy", int'(vif.busy), 0);
    chk("to_early_credit", int'(vif.credit), 2);
    tick();
    chk("to_busy", int'(vif.busy), 1);
    chk("to_chg_req", int'(vif.chg_req), 1);
    vif.chg_ack = 1'b1; tick();
    vif.chg_ack = 1'b1; tick();
    chk("to_refund_credit", int'(vif.credit), 0);
    chk("to_refund_busy", int'(vif.busy), 0);

    // Price writes: honoured in IDLE, ignored during DISPENSE.
    vif.cfg_we = 1'b1; vif.cfg_addr = 2'd3; vif.cfg_price = 3'd5; tick();
    coin(2'b11); tick();
    sel(3); tick();
    chk("cfg_nf", int'(vif.no_funds), 1);
    chk("cfg_nf_credit", int'(vif.credit), 4);
    sel(0); tick();
    chk("cfg_disp_req", int'(vif.disp_req), 1);
    chk("cfg_disp_credit", int'(vif.credit), 1);
    vif.cfg_we = 1'b1; vif.cfg_addr = 2'd0; vif.cfg_price = 3'd1; tick();
    vif.disp_ack = 1'b1; tick();
    chk("cfg_chg_req", int'(vif.chg_req), 1);
    vif.chg_ack = 1'b1; tick();
    coin(2'b01); tick();
    coin(2'b01); tick();
    sel(0); tick();
    chk("cfg_ignored_nf", int'(vif.no_funds), 1);
    chk("cfg_ignored_busy", int'(vif.busy), 0);
    vif.cancel = 1'b1; tick();
    chk("pre_rst_chg_req", int'(vif.chg_req), 1);
    rst = 1'b1; coin(2'b01); tick();
    chk("mid_rst_credit", int'(vif.credit), 0);
    chk("mid_rst_busy", int'(vif.busy), 0);
    chk("mid_rst_chg_req", int'(vif.chg_req), 0);
    chk("mid_rst_flags", int'({vif.disp_req, vif.coin_reject, vif.no_funds}), 0);

    // Free item.
    vif.cfg_we = 1'b1; vif.cfg_addr = 2'd1; vif.cfg_price = 3'd0; tick();
    coin(2'b01); tick();
    sel(1); tick();
    chk("free_disp_id", int'(vif.disp_id), 1);
    chk("free_credit", int'(vif.credit), 1);

    // Randomized traffic against the model, with quiet stretches to reach timeouts.
    for (int i = 0; i < 4000; i++) begin
      if ((i % 400) < 320) begin
        vif.coin_valid = 1'($urandom_range(0, 99) < 30);
        vif.coin_code  = 2'($urandom_range(0, 3));
        vif.sel_valid  = 1'($urandom_range(0, 99) < 15);
        vif.sel_id     = 2'($urandom_range(0, NP - 1));
        vif.cancel     = 1'($urandom_range(0, 99) < 4);
      end
      vif.cfg_we    = 1'($urandom_range(0, 99) < 6);
      vif.cfg_addr  = 2'($urandom_range(0, NP - 1));
      vif.cfg_price = 3'($urandom_range(0, CMAX));
      vif.disp_ack  = 1'($urandom_range(0, 99) < 30);
      vif.chg_ack   = 1'($urandom_range(0, 99) < 50);
      rst           = 1'($urandom_range(0, 399) == 0);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Transaction controller for a multi-product vending machine. It accumulates coin credit, checks a product selection against a runtime-configurable price table, and drives a dispenser handshake. It then returns leftover credit one unit at a time over a change-dispenser handshake, and handles cancel and inactivity timeout. It sits between the coin acceptor and keypad front-end and the dispense and change mechanisms.

Parameters:
CREDIT_W, 6, credit register width in units of the smallest coin; CREDIT_MAX = 2^CREDIT_W-1
N_PROD, 4, number of products; ID width = clog2(N_PROD)
DEFAULT_PRICE, 3, reset price of every product, in units
TIMEOUT, 1000, idle cycles in CREDIT before automatic refund

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
coin_valid  in  1  one-cycle coin event
coin_code  in  2  00=invalid, 01=1 unit, 10=2 units, 11=4 units
sel_valid  in  1  one-cycle product selection
sel_id  in  clog2(N_PROD)  selected product
cancel  in  1  one-cycle refund request
cfg_we  in  1  price write strobe
cfg_addr  in  clog2(N_PROD)  product to reprice
cfg_price  in  CREDIT_W  new price in units
disp_req  out  1  dispense request, held until disp_ack
disp_id  out  clog2(N_PROD)  product to dispense, stable while disp_req=1
disp_ack  in  1  dispenser done
chg_req  out  1  request one unit of change
chg_ack  in  1  one unit returned
credit  out  CREDIT_W  current credit
coin_reject  out  1  one-cycle pulse: coin not accepted
no_funds  out  1  one-cycle pulse: selection refused
busy  out  1  1 in DISPENSE or CHANGE

Behaviour:
- Reset: state=IDLE; credit=0; timer=0; all outputs 0; every price=DEFAULT_PRICE. Reset mid-transaction discards credit without refund.
- IDLE:
  - Valid coin: credit=value, go to CREDIT.
  - coin_code=00: coin_reject.
  - sel_valid: no_funds.
  - cancel: ignored.
- CREDIT, one event per cycle, priority cancel > sel > coin. A coin coincident with a higher-priority event is rejected (coin_reject).
  - cancel: go to CHANGE.
  - sel_valid with credit >= price[sel_id]: credit -= price, disp_id=sel_id, go to DISPENSE.
  - sel_valid with credit < price[sel_id]: no_funds; stay in CREDIT.
  - Coin: credit += value if the result is <= CREDIT_MAX; otherwise coin_reject and credit unchanged.
  - Timer clears on any accepted coin or refused selection and increments otherwise. When timer reaches TIMEOUT-1, go to CHANGE.
- DISPENSE:
  - disp_req=1 from the cycle after entry.
  - On a disp_ack cycle, disp_req drops next cycle; go to CHANGE if credit>0, else IDLE.
  - All coins are rejected; sel_valid and cancel are ignored.
- CHANGE:
  - chg_req=1 while credit>0. Each cycle with chg_req & chg_ack decrements credit by 1.
  - When credit reaches 0, chg_req=0 next cycle; go to IDLE.
  - Coins are rejected; sel_valid and cancel are ignored. A zero-price dispense with credit=0 skips CHANGE.
- Handshake ack while req=0 is ignored. Credit never underflows or wraps.
- Price table:
  - cfg_we applies only in IDLE, written at the clock edge; it is ignored in other states.
  - Price 0 is legal (free item).
- Latency: outputs are registered. credit reflects an accepted coin one cycle after coin_valid.

Decomposition:
- Package vend_pkg: state enum (IDLE, CREDIT, DISPENSE, CHANGE), coin_code constants, coin_value function (code to units).
- Sub-module vend_price_table: N_PROD x CREDIT_W register file with reset to DEFAULT_PRICE, one write port (cfg_*) and one combinational read port (sel_id -> price).

Test Plan:
- Coins 01, 10 (credit 3), select id0 (price 3), ack after 2 cycles -> disp_req=1 with disp_id=0 until ack; credit 0; back to IDLE; chg_req never asserted.
- Coins 11, 10 (credit 6), select id1 -> credit 3; dispense; then 3 chg_req/chg_ack cycles -> credit 3,2,1,0; IDLE.
- Credit 1, select id2 (price 3) -> no_funds pulse, credit 1; then cancel -> one change unit; IDLE.
- CREDIT_W=3, credit 6, coin 10 -> coin_reject, credit stays 6. Coin + cancel in the same cycle -> coin_reject; refund of 6 units.
- Credit 2, no activity for TIMEOUT cycles -> CHANGE entered exactly at the timeout; 2 units returned.
- cfg write price 5 to id3 in IDLE, then cfg write during DISPENSE ignored. Credit 4, select id3 -> no_funds. Assert rst while in CHANGE -> credit 0, all outputs 0 the next cycle.
